imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart of the read-only instruction memory.
- Receives a byte stream (e.g. from a UART receiver) and assembles little-endian 32-bit instructions.
- Writes each instruction into the instruction memory's write port at consecutive word-aligned byte addresses.
- Holds the core in stall while a program load is in progress.

Parameters:
- DEPTH_WORDS, 1024, instruction memory capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-aligned.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- load_len  input  32  number of words to load; sampled with start.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  incoming program byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  32  byte address of the write; always 4-aligned.
- mem_wdata  output  32  assembled instruction.
- busy  output  1  load in progress.
- cpu_hold  output  1  stall/hold request to the core; equals busy.
- done  output  1  one-cycle pulse on load completion.
- error  output  1  one-cycle pulse on rejected start (load_len > DEPTH_WORDS).

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0: byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error.
  - Byte and word counters are cleared.
  - Reset mid-load abandons the load immediately; words already written stay in memory.
- A byte handshake occurs when byte_valid && byte_ready on a rising edge.
- IDLE:
  - byte_ready=0, busy=0.
  - start && load_len==0: done=1 next cycle, stay IDLE.
  - start && load_len>DEPTH_WORDS: error=1 next cycle, stay IDLE, nothing written.
  - start with valid length: latch load_len, clear word_idx and byte_idx, go to RECV.
- RECV:
  - byte_ready=1, busy=1.
  - Each handshake stores byte_data into shift buffer lane byte_idx; byte_idx 0 fills bits [7:0], byte_idx 3 fills [31:24].
  - On the handshake with byte_idx==3, go to WRITE; byte_idx wraps to 0.
  - byte_valid low simply waits; no timeout.
- WRITE (exactly one cycle):
  - byte_ready=0, mem_we=1.
  - mem_addr = BASE_ADDR + (word_idx<<2); mem_wdata = assembled word.
  - Latency: mem_we is high the cycle immediately after the 4th byte handshake.
  - Then word_idx increments; if the new word_idx==latched length go to DONE, else go to RECV.
- DONE (one cycle): done=1, busy=0, cpu_hold=0; return to IDLE.
- mem_addr and mem_wdata hold their last values outside WRITE; consumers qualify them with mem_we.
- start outside IDLE is ignored; the latched length is unaffected.
- Arithmetic: word_idx is 32 bits and never exceeds DEPTH_WORDS, so mem_addr never wraps.
- done and error are never asserted in the same cycle.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release -> all outputs 0; byte_ready stays 0 with byte_valid=1 and no start.
- Two-word load: start with load_len=2, bytes 13,00,00,00,93,00,10,00 back-to-back -> mem_we at addr 0 with 32'h00000013 one cycle after 4th byte, then addr 4 with 32'h00100093, then done pulse; busy/cpu_hold high from cycle after start until DONE.
- Gapped stream: same load with byte_valid low 5 cycles between each byte -> identical writes; no mem_we until the 4th byte is accepted.
- Boundary lengths:
  - load_len=0 -> done one cycle later, no mem_we.
  - load_len=1025 -> error pulse, no writes, busy stays 0.
  - load_len=1024 -> final write at addr 32'hFFC, then done.
- Reset mid-load: assert rst_n=0 after 6 bytes of a 2-word load -> outputs 0 immediately; a new start with load_len=1 and 4 bytes writes the new word at addr 0.
- Start while busy: pulse start with load_len=5 mid-load of load_len=2 -> ignored; exactly 2 writes then done.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status signals of the program loader.
// master = loader side, slave = environment (byte source, memory, core).
interface imem_loader_if;
  logic        start;
  logic [31:0] load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;

  modport master (
    input  start, load_len, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error
  );

  modport slave (
    output start, load_len, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Assembles a little-endian byte stream into 32-bit instructions and writes them to
// consecutive word addresses of the instruction memory, holding the core while loading.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst_n,
  imem_loader_if.master bus
);

  localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t      state, state_d;
  logic [31:0] len_q;
  logic [31:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] shift_q;
  logic        hs_c;
  logic        accept_c;
  logic        error_c;
  logic [31:0] word_inc_c;

  assign hs_c       = bus.byte_valid && bus.byte_ready;
  assign word_inc_c = word_idx + 32'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state decode; a zero-length load goes straight to DONE for its completion pulse
  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    error_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.load_len == 32'd0) begin
            state_d = DONE;
          end else if (bus.load_len > DEPTH) begin
            error_c = 1'b1;
          end else begin
            accept_c = 1'b1;
            state_d  = RECV;
          end
        end
      end
      RECV:    if (hs_c && byte_idx == 2'd3) state_d = WRITE;
      WRITE:   state_d = (word_inc_c == len_q) ? DONE : RECV;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs, all decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q          <= 32'd0;
      word_idx       <= 32'd0;
      byte_idx       <= 2'd0;
      shift_q        <= 24'd0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= 32'd0;
      bus.mem_wdata  <= 32'd0;
      bus.busy       <= 1'b0;
      bus.cpu_hold   <= 1'b0;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      if (accept_c) begin
        len_q    <= bus.load_len;
        word_idx <= 32'd0;
        byte_idx <= 2'd0;
      end
      if (state == RECV && hs_c) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0: shift_q[7:0]   <= bus.byte_data;
          2'd1: shift_q[15:8]  <= bus.byte_data;
          2'd2: shift_q[23:16] <= bus.byte_data;
          default: begin
            bus.mem_wdata <= {bus.byte_data, shift_q};
            bus.mem_addr  <= BASE_ADDR + {word_idx[29:0], 2'b00};
          end
        endcase
      end
      if (state == WRITE) word_idx <= word_inc_c;
      bus.byte_ready <= (state_d == RECV);
      bus.mem_we     <= (state_d == WRITE);
      bus.busy       <= (state_d == RECV) || (state_d == WRITE);
      bus.cpu_hold   <= (state_d == RECV) || (state_d == WRITE);
      bus.done       <= (state_d == DONE);
      bus.error      <= error_c;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table-driven load scenarios plus reset and
// start-while-busy sequences, checked against hand-computed addresses and words.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst_n;
  imem_loader_if bus();

  imem_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0, err_cnt = 0, hold_bad = 0, both_bad = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  typedef struct {
    logic [31:0] len;
    int          gap;
    logic        exp_busy;
    int          exp_done;
    int          exp_err;
    logic [31:0] exp_last_addr;
  } vec_t;

  vec_t vecs[5];

  // Write/pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
    if (bus.done)                   done_cnt++;
    if (bus.error)                  err_cnt++;
    if (bus.cpu_hold !== bus.busy)  hold_bad++;
    if (bus.done && bus.error)      both_bad++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    if (k == 0)      return 32'h0000_0013;
    else if (k == 1) return 32'h0010_0093;
    else             return {16'(k), 16'hC0DE};
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w, input int b);
    return w[8*b +: 8];
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // Entered at a falling edge; returns at the falling edge after the handshake
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    t = 0;
    while (!bus.byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.byte_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL byte_timeout: got byte_ready=0 expected 1");
    end
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [31:0] len);
    bus.start    = 1'b1;
    bus.load_len = len;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done expected pulse");
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] w;
    int bad;
    int nwr;
    clear_log();
    pulse_start(v.len);
    chk("busy_after_start", 32'(bus.busy), 32'(v.exp_busy));
    chk("done_after_start", 32'(bus.done), (v.len == 0) ? 32'd1 : 32'd0);
    chk("error_after_start", 32'(bus.error), 32'(v.exp_err));
    nwr = v.exp_busy ? int'(v.len) : 0;
    for (int k = 0; k < nwr; k++) begin
      w = exp_word(k);
      for (int b = 0; b < 4; b++) begin
        send_byte(word_byte(w, b), v.gap);
        if (k == 0 && b == 2) chk("no_we_before_4th", 32'(bus.mem_we), 32'd0);
        if (k == 0 && b == 3) begin
          chk("we_after_4th", 32'(bus.mem_we), 32'd1);
          chk("addr_word0", bus.mem_addr, 32'd0);
          chk("data_word0", bus.mem_wdata, 32'h0000_0013);
        end
      end
    end
    bus.byte_valid = 1'b0;
    if (v.exp_done != 0) wait_done();
    repeat (3) @(negedge clk);
    chk("write_count", 32'(wr_addr.size()), 32'(nwr));
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < nwr; i++)
      if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== exp_word(i)) bad++;
    chk("write_log_errors", 32'(bad), 32'd0);
    if (nwr > 0 && wr_addr.size() > 0)
      chk("last_addr", wr_addr[wr_addr.size() - 1], v.exp_last_addr);
    chk("done_pulses", 32'(done_cnt), 32'(v.exp_done));
    chk("error_pulses", 32'(err_cnt), 32'(v.exp_err));
    chk("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{len: 32'd2,    gap: 0, exp_busy: 1'b1, exp_done: 1, exp_err: 0, exp_last_addr: 32'h4};
    vecs[1] = '{len: 32'd2,    gap: 5, exp_busy: 1'b1, exp_done: 1, exp_err: 0, exp_last_addr: 32'h4};
    vecs[2] = '{len: 32'd0,    gap: 0, exp_busy: 1'b0, exp_done: 1, exp_err: 0, exp_last_addr: 32'h0};
    vecs[3] = '{len: 32'd1025, gap: 0, exp_busy: 1'b0, exp_done: 0, exp_err: 1, exp_last_addr: 32'h0};
    vecs[4] = '{len: 32'd1024, gap: 0, exp_busy: 1'b1, exp_done: 1, exp_err: 0, exp_last_addr: 32'hFFC};

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.load_len   = 32'd0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;

    // Reset then idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_mem_addr",   bus.mem_addr,        32'd0);
    chk("rst_mem_wdata",  bus.mem_wdata,       32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_cpu_hold",   32'(bus.cpu_hold),   32'd0);
    chk("rst_done",       32'(bus.done),       32'd0);
    chk("rst_error",      32'(bus.error),      32'd0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    repeat (3) @(negedge clk);
    chk("idle_byte_ready", 32'(bus.byte_ready), 32'd0);
    bus.byte_valid = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset mid-load, then a fresh one-word load
    clear_log();
    pulse_start(32'd2);
    for (int b = 0; b < 6; b++) send_byte(word_byte(exp_word(b / 4), b % 4), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",       32'(bus.busy),       32'd0);
    chk("midrst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("midrst_mem_wdata",  bus.mem_wdata,       32'd0);
    chk("midrst_mem_addr",   bus.mem_addr,        32'd0);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(32'd1);
    for (int b = 0; b < 4; b++) send_byte(word_byte(32'hDEAD_BEEF, b), 0);
    bus.byte_valid = 1'b0;
    chk("reload_we",   32'(bus.mem_we), 32'd1);
    chk("reload_addr", bus.mem_addr,    32'd0);
    chk("reload_data", bus.mem_wdata,   32'hDEAD_BEEF);
    @(negedge clk);
    chk("reload_done", 32'(bus.done), 32'd1);

    // Start while busy is ignored
    repeat (2) @(negedge clk);
    clear_log();
    pulse_start(32'd2);
    for (int b = 0; b < 2; b++) send_byte(word_byte(exp_word(0), b), 0);
    bus.byte_valid = 1'b0;
    pulse_start(32'd5);
    for (int b = 2; b < 8; b++) send_byte(word_byte(exp_word(b / 4), b % 4), 0);
    bus.byte_valid = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    chk("busy_start_writes", 32'(wr_addr.size()), 32'd2);
    chk("busy_start_done",   32'(done_cnt),       32'd1);
    chk("busy_start_idle",   32'(bus.busy),       32'd0);
    if (wr_data.size() == 2) chk("busy_start_word1", wr_data[1], 32'h0010_0093);

    chk("hold_tracks_busy", 32'(hold_bad), 32'd0);
    chk("done_error_overlap", 32'(both_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
